vga_buffer_addr_scaler: RTL and testbench



---
 rtl/vga_buffer_addr_scaler_if.sv | 23 ++
 rtl/vga_buffer_addr_scaler.sv | 91 +++++++++
 tb/tb_vga_buffer_addr_scaler.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/vga_buffer_addr_scaler_if.sv
// vga_buffer_addr_scaler_if: position/config inputs and address/status outputs between VGA driver and address scaler
interface vga_buffer_addr_scaler_if #(
  parameter int PW = 10,
  parameter int AW = 15
);
  logic [PW-1:0] posX;
  logic [PW-1:0] posY;
  logic [1:0]    scale_sel;
  logic [PW-1:0] win_x0;
  logic [PW-1:0] win_y0;
  logic [AW-1:0] addr_out;
  logic          in_win;
  logic          frame_start;
  logic          seq_err;
  modport master (
    output posX, posY, scale_sel, win_x0, win_y0,
    input  addr_out, in_win, frame_start, seq_err
  );
  modport slave (
    input  posX, posY, scale_sel, win_x0, win_y0,
    output addr_out, in_win, frame_start, seq_err
  );
endinterface

// File: rtl/vga_buffer_addr_scaler.sv
// vga_buffer_addr_scaler: 2-stage VGA position to buffer address with 1x/2x/4x scaling, window origin, incremental rows (clk, rst, bus: posX/posY/scale_sel/win_x0/win_y0 in; addr_out/in_win/frame_start/seq_err out)
module vga_buffer_addr_scaler #(
  parameter int IMG_X    = 160,
  parameter int IMG_Y    = 120,
  parameter int AW       = 15,
  parameter int PW       = 10,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input logic clk,
  input logic rst,
  vga_buffer_addr_scaler_if.slave bus
);
  localparam int XW = PW + 2;
  localparam logic [AW-1:0] BLACK = AW'(IMG_X * IMG_Y);
  localparam logic [AW-1:0] ROW   = AW'(IMG_X);
  localparam logic [XW-1:0] IX    = XW'(IMG_X);
  localparam logic [XW-1:0] IY    = XW'(IMG_Y);
  localparam logic [PW-1:0] HA    = PW'(H_ACTIVE);
  localparam logic [PW-1:0] VA    = PW'(V_ACTIVE);
  logic [PW-1:0] r_x, r_y, r_prev_y, r_x0, r_y0;
  logic [1:0]    r_sc, r_vsub;
  logic [AW-1:0] r_rb, r_addr;
  logic          r_vld, r_seen, r_rsync, r_in, r_fs, r_err;
  logic [PW-1:0] w_x0, w_y0, w_col;
  logic [1:0]    w_sc, w_s, w_vmax, w_vsub;
  logic [XW-1:0] w_xhi, w_yhi;
  logic [AW-1:0] w_rb, w_addr;
  logic          w_fs0, w_chg, w_ymid, w_tclr, w_tinc, w_wrap, w_bad, w_rsync, w_win;
  always_comb begin
    w_fs0   = r_vld && r_x == '0 && r_y == '0;
    w_sc    = w_fs0 ? bus.scale_sel : r_sc;
    w_x0    = w_fs0 ? bus.win_x0 : r_x0;
    w_y0    = w_fs0 ? bus.win_y0 : r_y0;
    w_s     = (w_sc == 2'd0) ? 2'd0 : (w_sc == 2'd1) ? 2'd1 : 2'd2;
    w_vmax  = (w_s == 2'd0) ? 2'd0 : (w_s == 2'd1) ? 2'd1 : 2'd3;
    w_xhi   = {2'b00, w_x0} + (IX << w_s);
    w_yhi   = {2'b00, w_y0} + (IY << w_s);
    w_chg   = r_vld && r_y != r_prev_y;
    w_ymid  = r_y > w_y0 && {2'b00, r_y} < w_yhi;
    w_tclr  = w_chg && (r_y == '0 || r_y == w_y0);
    w_tinc  = w_chg && !w_tclr && w_ymid;
    w_wrap  = r_vsub == w_vmax;
    w_vsub  = w_tclr ? 2'd0 : !w_tinc ? r_vsub : w_wrap ? 2'd0 : r_vsub + 2'd1;
    w_rb    = w_tclr ? '0 : (w_tinc && w_wrap) ? r_rb + ROW : r_rb;
    w_bad   = w_chg && r_seen && r_y != r_prev_y + PW'(1) && r_y != '0;
    w_rsync = (r_vld && r_y == '0) ? 1'b0 : (r_rsync || w_bad);
    w_win   = r_vld && !w_rsync && r_x < HA && r_y < VA && r_x >= w_x0 && {2'b00, r_x} < w_xhi && r_y >= w_y0 && {2'b00, r_y} < w_yhi;
    w_col   = (r_x - w_x0) >> w_s;
    w_addr  = w_win ? w_rb + AW'(w_col) : BLACK;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_vld    <= 1'b0;
      r_sc     <= bus.scale_sel;
      r_x0     <= bus.win_x0;
      r_y0     <= bus.win_y0;
      r_rb     <= '0;
      r_vsub   <= '0;
      r_prev_y <= '0;
      r_seen   <= 1'b0;
      r_rsync  <= 1'b0;
      r_addr   <= BLACK;
      r_in     <= 1'b0;
      r_fs     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_x      <= bus.posX;
      r_y      <= bus.posY;
      r_vld    <= 1'b1;
      r_sc     <= w_sc;
      r_x0     <= w_x0;
      r_y0     <= w_y0;
      r_rb     <= w_rb;
      r_vsub   <= w_vsub;
      r_prev_y <= r_vld ? r_y : r_prev_y;
      r_seen   <= r_seen | r_vld;
      r_rsync  <= w_rsync;
      r_addr   <= w_addr;
      r_in     <= w_win;
      r_fs     <= w_fs0;
      r_err    <= r_err | w_bad;
    end
  end
  assign bus.addr_out    = r_addr;
  assign bus.in_win      = r_in;
  assign bus.frame_start = r_fs;
  assign bus.seq_err     = r_err;
endmodule

// File: tb/tb_vga_buffer_addr_scaler.sv
// tb_vga_buffer_addr_scaler: directed frames checked every cycle against an arithmetic model plus literal pins
module tb_vga_buffer_addr_scaler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  vga_buffer_addr_scaler_if #(.PW(10), .AW(15)) bus();
  vga_buffer_addr_scaler dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int n_run = 0;
  int n_fail = 0;
  int fs_cnt = 0;
  int lit_a = -1;
  int lit_i = 0;
  typedef struct {bit v; int x; int y; int la; int li;} smp_t;
  typedef struct {int x; int y; int a; int i;} pin_t;
  smp_t s1;
  pin_t pins[$];
  int m_s, m_x0, m_y0, m_prev;
  bit m_seen, m_rsync, m_err, m_trust;
  int xs[14] = '{0, 3, 5, 159, 160, 239, 240, 241, 319, 320, 399, 400, 639, 700};
  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    smp_t cur;
    bit r, efs, ew;
    int s, ea;
    r = rst;
    cur.v = !rst;
    cur.x = int'(bus.posX);
    cur.y = int'(bus.posY);
    cur.la = lit_a;
    cur.li = lit_i;
    efs = 0; ew = 0; ea = 19200;
    if (r) begin
      m_s = int'(bus.scale_sel); m_x0 = int'(bus.win_x0); m_y0 = int'(bus.win_y0);
      m_seen = 0; m_rsync = 0; m_err = 0; m_trust = 0;
    end else if (s1.v) begin
      efs = s1.x == 0 && s1.y == 0;
      if (efs) begin
        m_s = int'(bus.scale_sel); m_x0 = int'(bus.win_x0); m_y0 = int'(bus.win_y0);
      end
      if (m_seen && s1.y != m_prev && s1.y != m_prev + 1 && s1.y != 0) begin
        m_err = 1; m_rsync = 1;
      end
      if (s1.y == 0) begin
        m_rsync = 0; m_trust = 1;
      end
      m_seen = 1;
      m_prev = s1.y;
      s = (m_s == 0) ? 0 : (m_s == 1) ? 1 : 2;
      ew = !m_rsync && s1.x < 640 && s1.y < 480 && s1.x >= m_x0 && s1.x < m_x0 + (160 << s)
           && s1.y >= m_y0 && s1.y < m_y0 + (120 << s);
      ea = ew ? ((s1.y - m_y0) >> s) * 160 + ((s1.x - m_x0) >> s) : 19200;
    end
    #1;
    if (bus.frame_start) fs_cnt++;
    if (r) begin
      chk("rst_addr", int'(bus.addr_out), 19200);
      chk("rst_in_win", int'(bus.in_win), 0);
      chk("rst_frame_start", int'(bus.frame_start), 0);
      chk("rst_seq_err", int'(bus.seq_err), 0);
    end else if (s1.v) begin
      if (m_trust || !ew) chk("addr", int'(bus.addr_out), ea);
      chk("in_win", int'(bus.in_win), int'(ew));
      chk("frame_start", int'(bus.frame_start), int'(efs));
      chk("seq_err", int'(bus.seq_err), int'(m_err));
      if (s1.la >= 0) begin
        chk("pin_addr", int'(bus.addr_out), s1.la);
        chk("pin_in_win", int'(bus.in_win), s1.li);
      end
    end
    s1 = cur;
  end
  task automatic d(input int x, input int y, input int la = -1, input int li = 0);
    @(negedge clk);
    bus.posX = 10'(x);
    bus.posY = 10'(y);
    lit_a = la;
    lit_i = li;
  endtask
  task automatic pin(input int x, input int y, input int a, input int i);
    pins.push_back('{x, y, a, i});
  endtask
  task automatic cfg(input int s, input int x0, input int y0);
    bus.scale_sel = 2'(s);
    bus.win_x0 = 10'(x0);
    bus.win_y0 = 10'(y0);
  endtask
  task automatic frame(input int ny, input int jf = -1, input int jt = 0, input int cr = -1, input int cv = 0, input int rr = -1);
    int y = 0;
    while (y < ny) begin
      foreach (xs[i]) d(xs[i], y);
      foreach (pins[i]) if (pins[i].y == y) d(pins[i].x, y, pins[i].a, pins[i].i);
      if (y == cr) bus.scale_sel = 2'(cv);
      if (y == rr) begin
        @(negedge clk);
        rst = 1'b1;
        lit_a = -1;
        @(negedge clk);
        rst = 1'b0;
      end
      y = (y == jf) ? jt : y + 1;
    end
    pins.delete();
  endtask
  initial begin
    cfg(0, 0, 0);
    bus.posX = 10'd700;
    bus.posY = 10'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    pin(5, 2, 325, 1); pin(160, 2, 19200, 0);
    frame(125);
    cfg(1, 0, 0);
    pin(5, 3, 162, 1); pin(319, 239, 19199, 1); pin(320, 0, 19200, 0);
    frame(245);
    cfg(2, 0, 0);
    pin(639, 479, 19199, 1); pin(4, 4, 161, 1); pin(700, 10, 19200, 0);
    frame(480);
    cfg(0, 240, 180);
    pin(240, 180, 0, 1); pin(239, 180, 19200, 0); pin(399, 299, 19199, 1);
    frame(305);
    cfg(0, 0, 0);
    pin(5, 60, 9605, 1);
    frame(70, -1, 0, 50, 1);
    pin(5, 60, 4802, 1);
    frame(70);
    cfg(0, 0, 0);
    pin(5, 25, 19200, 0);
    frame(40, 10, 20);
    @(negedge clk);
    chk("seq_err_sticky", int'(bus.seq_err), 1);
    pin(5, 60, 9605, 1);
    frame(70);
    pin(5, 3, 485, 1);
    frame(60, -1, 0, -1, 0, 30);
    pin(5, 3, 485, 1);
    frame(40);
    d(700, 40);
    repeat (3) @(negedge clk);
    chk("frame_count", fs_cnt, 10);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
